// File: rtl/integer_accum_if.sv
// Valid/ready bundle between the +10 adder, the batch accumulator and the next stage.
// master drives samples and sum_ready; slave is the accumulator.
interface integer_accum_if #(
    parameter int unsigned DATA_W = 32
);
    logic [DATA_W-1:0] in_val;
    logic              in_valid;
    logic              in_ready;
    logic              clear;
    logic [DATA_W-1:0] sum_out;
    logic              sum_valid;
    logic              sum_ready;
    logic              ovf;
    logic [7:0]        count;

    modport master (
        output in_val, in_valid, clear, sum_ready,
        input  in_ready, sum_out, sum_valid, ovf, count
    );

    modport slave (
        input  in_val, in_valid, clear, sum_ready,
        output in_ready, sum_out, sum_valid, ovf, count
    );
endinterface

// File: rtl/integer_accum.sv
// Accumulates BATCH unsigned samples from the +10 adder and presents a held, flow-controlled sum.
// Optional ACC_SATURATE_EN: on carry the accumulator clamps to all-ones instead of wrapping.
module integer_accum #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned BATCH  = 4
) (
    input logic            clk,
    input logic            rst,
    integer_accum_if.slave bus
);
    localparam int unsigned       CNT_W     = 8;
    localparam logic [CNT_W-1:0]  BATCH_CNT = CNT_W'(BATCH);
    localparam logic [DATA_W-1:0] ACC_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              in_ready_q, in_ready_d;
    logic              sum_valid_q, sum_valid_d;
    logic              accept_c;
    logic [DATA_W:0]   add_c;
    logic [CNT_W-1:0]  cnt_inc_c;

    // State and datapath registers; in_ready is held low during reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            sum_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    // Next-state and datapath update; clear overrides every handshake
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        accept_c  = bus.in_valid && in_ready_q;
        add_c     = {1'b0, acc_q} + {1'b0, bus.in_val};
        cnt_inc_c = cnt_q + CNT_W'(1);

        if (bus.clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        acc_d   = bus.in_val;
                        cnt_d   = CNT_W'(1);
                        ovf_d   = 1'b0;
                        state_d = (BATCH_CNT == CNT_W'(1)) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept_c) begin
                        cnt_d = cnt_inc_c;
                        if (add_c[DATA_W]) begin
                            ovf_d = 1'b1;
                        end
`ifdef ACC_SATURATE_EN
                        // Once clamped, further adds carry or add zero, so acc stays at all-ones
                        acc_d = add_c[DATA_W] ? ACC_MAX : add_c[DATA_W-1:0];
`else
                        acc_d = add_c[DATA_W-1:0];
`endif
                        if (cnt_inc_c == BATCH_CNT) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.sum_ready) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end

        // Handshake flags are registered decodes of the next state
        in_ready_d  = (state_d != DONE);
        sum_valid_d = (state_d == DONE);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.sum_valid = sum_valid_q;
    assign bus.sum_out   = acc_q;
    assign bus.ovf       = ovf_q;
    assign bus.count     = cnt_q;

endmodule
